// File: rtl/optical_sched_pkg.sv
// Shared definitions for the optical slot scheduler.
// Contents:
//   - state_t  : scheduler FSM states
//   - SCHED_N  : default port count
//   - W        : index width for the default port count
//   - rr_first : cyclic first-set-bit at or after a pointer. The search
//                width is passed at run time and the vector is capped at
//                32 bits, so one function serves any port count.
package optical_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ACCEPT,
        CFG,
        GUARD,
        SLOT
    } state_t;

    localparam int SCHED_N = 8;
    localparam int W       = $clog2(SCHED_N);

    // Returns a one-hot vector with the first set bit of req[n-1:0],
    // scanning upward from ptr and wrapping from n-1 back to 0.
    // Returns zero when no bit is set. Requires ptr < n <= 32.
    function automatic logic [31:0] rr_first(input logic [31:0] req,
                                             input logic [31:0] ptr,
                                             input int          n);
        logic [31:0] pick;
        logic [31:0] idx;
        logic        found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            idx = ptr + 32'(k);
            if (idx >= 32'(n)) idx = idx - 32'(n);
            if (k < n && !found && req[idx[4:0]]) begin
                pick[idx[4:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sched_rr_pick.sv
// Combinational round-robin picker: one-hot selection of the first
// requester at or after the pointer, cyclically.
// Ports:
//   req  : N-bit request vector
//   ptr  : W-bit round-robin pointer (< N)
//   pick : N-bit one-hot result (zero when req is zero)
module sched_rr_pick
    import optical_sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    assign pick = N'(rr_first(32'(req), 32'(ptr), N));

endmodule

// File: rtl/optical_slot_scheduler.sv
// Single-iteration iSLIP scheduler for the NxN optical crossbar.
// Each slot: latch a request matrix, run one round-robin grant stage and
// one accept stage, hand the matching to the switch driver over a
// valid/ready handshake, wait the reconfiguration guard time, then run
// the data slot.
// Ports:
//   i_clk, i_rst                     clock, async active-high reset
//   i_req[N*N], i_req_valid          request matrix (bit i*N+j: in i -> out j)
//   o_req_ready                      idle, accepting a matrix
//   i_reset_priority                 synchronous clear of all RR pointers
//   o_cfg_map[N*W], o_cfg_en[N]      per-output input index / enable
//   o_cfg_valid, i_cfg_ready         configuration handshake
//   o_slot_active, o_slot_done       data slot status
// Optional: define SCHED_STATS_EN to add o_stat_slots / o_stat_pairs
// (saturating counts of completed slots and of connected pairs).
module optical_slot_scheduler
    import optical_sched_pkg::*;
#(
    parameter int P_PORT_NUM     = SCHED_N,
    parameter int P_GUARD_CYCLES = 16,
    parameter int P_SLOT_CYCLES  = 64
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic [P_PORT_NUM*P_PORT_NUM-1:0]           i_req,
    input  logic                                       i_req_valid,
    output logic                                       o_req_ready,
    input  logic                                       i_reset_priority,
    output logic [P_PORT_NUM*$clog2(P_PORT_NUM)-1:0]   o_cfg_map,
    output logic [P_PORT_NUM-1:0]                      o_cfg_en,
    output logic                                       o_cfg_valid,
    input  logic                                       i_cfg_ready,
    output logic                                       o_slot_active,
`ifdef SCHED_STATS_EN
    output logic [31:0]                                o_stat_slots,
    output logic [31:0]                                o_stat_pairs,
`endif
    output logic                                       o_slot_done
);

    localparam int N    = P_PORT_NUM;
    localparam int PW   = $clog2(N);
    localparam int CMAX = (P_GUARD_CYCLES > P_SLOT_CYCLES) ? P_GUARD_CYCLES : P_SLOT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [N*N-1:0]      req_q;
    // gnt_q[j] / gnt_nx[j]: one-hot over inputs, output j's grant
    logic [N-1:0][N-1:0] gnt_q, gnt_nx;
    // acc[i]: one-hot over outputs, input i's accept
    logic [N-1:0][N-1:0] acc;
    logic [N-1:0][N-1:0] req_col, gnt_row;
    logic [N-1:0][PW-1:0] g_ptr, a_ptr;
    logic [N-1:0][PW-1:0] map_acc, map_nx, cfg_map_q;
    logic [N-1:0]        en_acc, en_nx;
    logic                done_nx;

    for (genvar j = 0; j < N; j++) begin : g_xpose
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign req_col[j][i] = req_q[i*N + j];
            assign gnt_row[i][j] = gnt_q[j][i];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_pick
        sched_rr_pick #(.N(N), .PW(PW)) u_gnt (
            .req  (req_col[k]),
            .ptr  (g_ptr[k]),
            .pick (gnt_nx[k])
        );
        sched_rr_pick #(.N(N), .PW(PW)) u_acc (
            .req  (gnt_row[k]),
            .ptr  (a_ptr[k]),
            .pick (acc[k])
        );
    end

    // Accepted pairs -> per-output configuration
    always_comb begin
        en_acc  = '0;
        map_acc = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (acc[i][j]) begin
                    en_acc[j]  = 1'b1;
                    map_acc[j] = PW'(i);
                end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        map_nx   = cfg_map_q;
        en_nx    = o_cfg_en;
        case (state)
            IDLE:   if (i_req_valid) state_nx = GRANT;
            GRANT:  state_nx = ACCEPT;
            ACCEPT: begin
                if (|en_acc) begin
                    state_nx = CFG;
                    map_nx   = map_acc;
                    en_nx    = en_acc;
                end else begin
                    state_nx = IDLE;
                end
            end
            CFG: if (i_cfg_ready) begin
                state_nx = GUARD;
                cnt_nx   = '0;
            end
            GUARD: if (cnt == CW'(P_GUARD_CYCLES - 1)) begin
                state_nx = SLOT;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            SLOT: if (cnt == CW'(P_SLOT_CYCLES - 1)) begin
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == IDLE) begin
            map_nx = '0;
            en_nx  = '0;
        end
        // Empty request matrix means empty grants, hence empty matching;
        // deciding in GRANT lets the registered pulse land in the ACCEPT cycle.
        done_nx = (state == GRANT && req_q == '0) ||
                  (state_nx == SLOT && cnt_nx == CW'(P_SLOT_CYCLES - 1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            req_q         <= '0;
            gnt_q         <= '0;
            cfg_map_q     <= '0;
            o_cfg_en      <= '0;
            o_cfg_valid   <= 1'b0;
            o_slot_active <= 1'b0;
            o_slot_done   <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            cfg_map_q     <= map_nx;
            o_cfg_en      <= en_nx;
            o_cfg_valid   <= (state_nx == CFG);
            o_slot_active <= (state_nx == SLOT);
            o_slot_done   <= done_nx;
            if (state == IDLE && i_req_valid) req_q <= i_req;
            if (state == GRANT) gnt_q <= gnt_nx;
        end
    end

    // Pointer clear takes priority over the ACCEPT-cycle update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            g_ptr <= '0;
            a_ptr <= '0;
        end else if (i_reset_priority) begin
            g_ptr <= '0;
            a_ptr <= '0;
        end else if (state == ACCEPT) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (acc[i][j]) begin
                        g_ptr[j] <= (i == N-1) ? '0 : PW'(i + 1);
                        a_ptr[i] <= (j == N-1) ? '0 : PW'(j + 1);
                    end
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_cfg_map   = cfg_map_q;

`ifdef SCHED_STATS_EN
    logic [32:0] pairs_sum;
    assign pairs_sum = {1'b0, o_stat_pairs} + 33'($countones(o_cfg_en));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat_slots <= '0;
            o_stat_pairs <= '0;
        end else begin
            if (state == SLOT && cnt == CW'(P_SLOT_CYCLES - 1) && o_stat_slots != '1)
                o_stat_slots <= o_stat_slots + 1'b1;
            if (state == CFG && i_cfg_ready)
                o_stat_pairs <= pairs_sum[32] ? '1 : pairs_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_optical_slot_scheduler.sv
module tb_optical_slot_scheduler;

    localparam int N = 8;
    localparam int G = 16;
    localparam int S = 64;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [63:0]   i_req;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_reset_priority;
    logic [23:0]   o_cfg_map;
    logic [7:0]    o_cfg_en;
    logic          o_cfg_valid;
    logic          i_cfg_ready;
    logic          o_slot_active;
    logic          o_slot_done;

    optical_slot_scheduler #(
        .P_PORT_NUM(N), .P_GUARD_CYCLES(G), .P_SLOT_CYCLES(S)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_reset_priority(i_reset_priority),
        .o_cfg_map(o_cfg_map), .o_cfg_en(o_cfg_en), .o_cfg_valid(o_cfg_valid),
        .i_cfg_ready(i_cfg_ready), .o_slot_active(o_slot_active),
        .o_slot_done(o_slot_done)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference state: round-robin pointers as plain integers
    int gp[N];
    int ap[N];
    logic [7:0]  exp_en;
    logic [23:0] exp_map;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // iSLIP single iteration from the textual rules, then pointer update
    task automatic model_match(input logic [63:0] req, input bit clr);
        int grant[N];
        int acc_out[N];
        exp_en  = '0;
        exp_map = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (gp[j] + k) % N;
                if (grant[j] < 0 && req[i*N + j]) grant[j] = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            acc_out[i] = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ap[i] + k) % N;
                if (acc_out[i] < 0 && grant[j] == i) acc_out[i] = j;
            end
        end
        for (int i = 0; i < N; i++)
            if (acc_out[i] >= 0) begin
                exp_en[acc_out[i]] = 1'b1;
                exp_map[acc_out[i]*3 +: 3] = 3'(i);
            end
        if (clr) begin
            for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        end else begin
            for (int i = 0; i < N; i++)
                if (acc_out[i] >= 0) begin
                    gp[acc_out[i]] = (i + 1) % N;
                    ap[i] = (acc_out[i] + 1) % N;
                end
        end
    endtask

    task automatic chk_ptrs(input string tag);
        logic [23:0] eg, ea;
        for (int k = 0; k < N; k++) begin
            eg[k*3 +: 3] = 3'(gp[k]);
            ea[k*3 +: 3] = 3'(ap[k]);
        end
        chk({tag, "_gptr"}, 64'(dut.g_ptr), 64'(eg));
        chk({tag, "_aptr"}, 64'(dut.a_ptr), 64'(ea));
    endtask

    // Runs one full slot starting from an IDLE negedge; ends at the
    // negedge of the first IDLE cycle afterwards.
    task automatic do_slot(input string tag, input logic [63:0] req,
                           input int rdy_delay, input bit rp);
        int first_act, n_act, done_t, hold_err, t;
        bit empty;
        model_match(req, rp);
        empty = (exp_en == '0);
        chk({tag, "_ready_idle"}, 64'(o_req_ready), 64'd1);
        i_req = req; i_req_valid = 1'b1;
        @(negedge i_clk);                       // cycle 1 GRANT
        i_req_valid = 1'b0;
        chk({tag, "_c1"}, {62'd0, o_cfg_valid, o_slot_done}, 64'd0);
        @(negedge i_clk);                       // cycle 2 ACCEPT
        chk({tag, "_c2_done"}, 64'(o_slot_done), 64'(empty));
        if (rp) i_reset_priority = 1'b1;
        @(negedge i_clk);                       // cycle 3
        i_reset_priority = 1'b0;
        if (empty) begin
            chk({tag, "_c3_empty"}, {o_req_ready, o_cfg_valid, o_slot_done, o_cfg_en},
                {3'b100, 8'h00});
            chk_ptrs(tag);
            return;
        end
        chk({tag, "_c3_cfg"}, {o_cfg_valid, o_cfg_en, o_cfg_map}, {1'b1, exp_en, exp_map});
        hold_err = 0;
        if (rdy_delay > 0) begin
            i_cfg_ready = 1'b0;
            repeat (rdy_delay) begin
                @(negedge i_clk);
                if (o_cfg_valid !== 1'b1 || o_cfg_map !== exp_map || o_cfg_en !== exp_en
                    || o_slot_active !== 1'b0)
                    hold_err++;
            end
            i_cfg_ready = 1'b1;                 // handshake this cycle
        end
        first_act = -1; n_act = 0; done_t = -1;
        for (t = 1; t <= G + S; t++) begin
            @(negedge i_clk);
            if (o_slot_active === 1'b1) begin
                if (first_act < 0) first_act = t;
                n_act++;
            end
            if (o_slot_done === 1'b1) done_t = (done_t < 0) ? t : -2;
            if (o_cfg_valid !== 1'b0 || o_cfg_map !== exp_map || o_cfg_en !== exp_en
                || o_req_ready !== 1'b0)
                hold_err++;
        end
        @(negedge i_clk);
        chk({tag, "_hold"}, 64'(hold_err), 64'd0);
        chk({tag, "_first_active"}, 64'(first_act), 64'(G + 1));
        chk({tag, "_active_len"}, 64'(n_act), 64'(S));
        chk({tag, "_done_at"}, 64'(done_t), 64'(G + S));
        chk({tag, "_back_idle"}, {o_req_ready, o_slot_active, o_slot_done, o_cfg_en, o_cfg_map},
            {3'b100, 8'h00, 24'h0});
        chk_ptrs(tag);
    endtask

    initial begin
        logic [63:0] r, ident, col0, two;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        i_rst = 1'b1; i_req = '0; i_req_valid = 1'b0;
        i_reset_priority = 1'b0; i_cfg_ready = 1'b1;
        #1;
        chk("reset_outs", {o_req_ready, o_cfg_valid, o_slot_active, o_slot_done, o_cfg_en, o_cfg_map},
            {4'b1000, 8'h00, 24'h0});
        chk_ptrs("reset");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // identity matrix: full connection, field j = j
        ident = '0;
        for (int k = 0; k < N; k++) ident[k*N + k] = 1'b1;
        do_slot("ident", ident, 0, 1'b0);
        chk("ident_map_const", {exp_en, exp_map}, {8'hFF, 24'hFAC688});

        // clear pointers from IDLE
        i_reset_priority = 1'b1;
        @(negedge i_clk);
        i_reset_priority = 1'b0;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        chk_ptrs("rp_idle");

        // all inputs want output 0: grant rotates 0,1,2,3
        col0 = '0;
        for (int k = 0; k < N; k++) col0[k*N] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            do_slot("col0", col0, 0, 1'b0);
            chk("col0_winner", {o_cfg_en, 24'(dut.g_ptr[0])}, {8'h00, 24'((s + 1) % N)});
        end

        do_slot("empty", 64'd0, 0, 1'b0);

        do_slot("stall10", ident | col0, 10, 1'b0);

        // 2x2 contention with pointers cleared
        i_reset_priority = 1'b1;
        @(negedge i_clk);
        i_reset_priority = 1'b0;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        two = 64'h0303;
        do_slot("two_a", two, 0, 1'b0);
        chk("two_a_pair", {exp_en, exp_map}, {8'h01, 24'h0});
        do_slot("two_b", two, 0, 1'b0);
        chk("two_b_pair", {exp_en, exp_map}, {8'h03, 24'h000001});

        // pointer clear coincident with the ACCEPT update
        do_slot("rp_acc", ident, 0, 1'b1);

        // randomized slots
        for (int s = 0; s < 30; s++) begin
            r = {$urandom, $urandom} & {$urandom, $urandom};
            if (s % 7 == 3) r = '0;
            do_slot("rand", r, int'($urandom_range(0, 3)), (s % 9 == 5));
        end

        // async reset in the middle of SLOT
        model_match(ident, 1'b0);
        i_req = ident; i_req_valid = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        repeat (3 + G + 10) @(negedge i_clk);
        chk("pre_rst_active", 64'(o_slot_active), 64'd1);
        i_rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
        chk("rst_slot_outs", {o_req_ready, o_cfg_valid, o_slot_active, o_slot_done, o_cfg_en, o_cfg_map},
            {4'b1000, 8'h00, 24'h0});
        chk_ptrs("rst_slot");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        do_slot("post_rst", ident, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/optical_slot_scheduler.md
# optical_slot_scheduler

Single-iteration iSLIP-style scheduler for the 8x8 optical crossbar. Each slot it samples an N×N request matrix and computes a conflict-free input→output matching with round-robin grant and accept stages. It then hands the configuration to the switch driver with a valid/ready handshake and sequences the reconfiguration guard time and the data slot. It sits between the per-port VOQ occupancy logic and the optical switch configuration interface.

## Interface
Parameters:
- P_PORT_NUM, 8, number of input and output ports (N ≥ 2); W = $clog2(N)
- P_GUARD_CYCLES, 16, optical reconfiguration guard time in cycles (≥ 1)
- P_SLOT_CYCLES, 64, data slot length in cycles (≥ 1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  N*N  request matrix; bit i*N+j = input i has traffic for output j
- i_req_valid  in  1  request matrix valid; sampled only when o_req_ready=1
- o_req_ready  out  1  scheduler idle, accepting a matrix
- i_reset_priority  in  1  synchronous reset of all RR pointers to 0
- o_cfg_map  out  N*W  field j = input index connected to output j
- o_cfg_en  out  N  bit j = output j connected this slot
- o_cfg_valid  out  1  configuration offered to switch driver
- i_cfg_ready  in  1  switch driver accepts configuration
- o_slot_active  out  1  data slot in progress
- o_slot_done  out  1  one-cycle pulse at end of slot or empty schedule

## Operation
- States: IDLE, GRANT, ACCEPT, CFG, GUARD, SLOT.
- IDLE: o_req_ready=1. When i_req_valid=1, register i_req and go to GRANT.
- GRANT (1 cycle): each output j grants the first requesting input at or after g_ptr[j], cyclically. The registered grant matrix is held for ACCEPT.
- ACCEPT (1 cycle): each input i accepts the first granting output at or after a_ptr[i], cyclically. This forms a matching.
  - Matching non-empty: load o_cfg_map/o_cfg_en and go to CFG.
  - Matching empty: pulse o_slot_done and return to IDLE.
- Pointer update occurs only in the ACCEPT cycle and only for accepted pairs (i,j): g_ptr[j] ← (i+1) mod N, a_ptr[i] ← (j+1) mod N. Unaccepted grants leave pointers unchanged. Wrap from N-1 to 0.
- CFG: o_cfg_valid=1 with map and en stable until the cycle where i_cfg_ready=1; then go to GUARD. i_cfg_ready while o_cfg_valid=0 is ignored.
- GUARD: count P_GUARD_CYCLES cycles, then go to SLOT.
- SLOT: o_slot_active=1 for exactly P_SLOT_CYCLES cycles. o_slot_done pulses in the last SLOT cycle, and the next cycle is IDLE.
- o_cfg_map fields with o_cfg_en=0 read 0. Map and en hold their values through GUARD and SLOT. They clear to 0 on entering IDLE.
- i_reset_priority clears all pointers in any state. If it coincides with the ACCEPT-cycle pointer update, the clear wins.
- Asynchronous reset mid-operation aborts to IDLE, clears pointers and counters, and drops o_cfg_valid immediately.

## Timing
- Reset values: o_req_ready=1, o_cfg_valid=0, o_cfg_map=0, o_cfg_en=0, o_slot_active=0, o_slot_done=0. All pointers are 0.
- Request accept (cycle 0) → o_cfg_valid high at cycle 3. Sequence: GRANT at cycle 1, ACCEPT at cycle 2.
- Handshake at cycle k → o_slot_active from cycle k+1+P_GUARD_CYCLES, for P_SLOT_CYCLES cycles.
- Empty schedule: o_slot_done in cycle 2, o_req_ready again at cycle 3.
- All outputs are registered except o_req_ready, which is decoded from the state register (state==IDLE).

## Configuration
- SCHED_STATS_EN defined: adds outputs o_stat_slots (32 bits) and o_stat_pairs (32 bits).
  - o_stat_slots counts completed non-empty slots.
  - o_stat_pairs accumulates the popcount of o_cfg_en at each handshake.
  - Both saturate at all-ones and clear on i_rst.
- SCHED_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `optical_sched_pkg` holds:
  - the state enum
  - the function computing cyclic first-set-at-or-after-pointer over N bits
  - the localparam W
- Sub-module `sched_rr_pick`: combinational one-hot pick from an N-bit request vector and a W-bit pointer. It is instantiated N times for grant and N times for accept.

## Test plan
- After reset, i_req = identity (input i→output i), i_cfg_ready tied 1:
  - o_cfg_en=8'hFF, field j=j
  - o_slot_active after 3+1+16 cycles, for 64 cycles
  - g_ptr[j]=a_ptr[j]=(j+1)%8
- All 8 inputs request only output 0, four consecutive slots: granted inputs are 0, 1, 2, 3 in turn.
- All-zero matrix → no o_cfg_valid, o_slot_done at cycle 2, o_req_ready at cycle 3, pointers unchanged.
- i_cfg_ready held 0 for 10 cycles in CFG → o_cfg_valid and o_cfg_map stable, GUARD starts only after ready.
- Inputs 0 and 1 both request outputs 0 and 1, pointers 0 → only pair (0,0) matched. Second slot with the same matrix → (1,0) and (0,1) matched.
- i_reset_priority pulsed in the ACCEPT cycle → all pointers read 0 afterwards. i_rst asserted during SLOT → all outputs at reset values immediately.
